// File: rtl/cp_pkg.sv
// Shared cyclic-prefix package: default framing geometry and read-sequencer state encoding.
// Reused by both the CP-insert and CP-delete sides of the OFDM path.
package cp_pkg;

  localparam int unsigned N_FFT  = 64;
  localparam int unsigned CP_LEN = 16;
  localparam int unsigned ADDR_W = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCp   = 2'd1,
    StBody = 2'd2
  } rd_state_e;

endpackage

// File: rtl/cp_wr_ctrl.sv
// Write side of the ping-pong sample RAM: bank/count addressing, full-flag set requests,
// upstream ready and sticky overflow.
module cp_wr_ctrl
  import cp_pkg::*;
#(
  parameter int unsigned NFft  = N_FFT,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ack_i,
  input  logic [1:0]       full_i,
  output logic             stb_o,
  output logic             we_o,
  output logic [AddrW:0]   waddr_o,
  output logic [1:0]       set_o,
  output logic             ovf_o
);

  localparam logic [AddrW-1:0] WLast = AddrW'(NFft - 1);

  logic             wbank_q, wbank_d;
  logic [AddrW-1:0] wcnt_q, wcnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    stb_o   = ~full_i[wbank_q];
    we_o    = ack_i & stb_o;
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    set_o   = 2'b00;
    // Samples offered while the write bank is full are dropped, not stalled.
    ovf_d   = ovf_q | (ack_i & ~stb_o);
    if (we_o) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == WLast) begin
        set_o[wbank_q] = 1'b1;
        wbank_d        = ~wbank_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbank_q <= 1'b0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbank_q <= wbank_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr_o = {wbank_q, wcnt_q};
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/cp_insert_sched.sv
// Cyclic-prefix insertion sequencer: replays each full bank as the symbol tail followed by
// the whole symbol, owning only addressing, bank ownership and framing flags.
module cp_insert_sched
  import cp_pkg::*;
#(
  parameter int unsigned NFft  = N_FFT,
  parameter int unsigned CpLen = CP_LEN,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ack_i,
  output logic           stb_o,
  input  logic           rdy_i,
  output logic           we_o,
  output logic [AddrW:0] waddr_o,
  output logic           re_o,
  output logic [AddrW:0] raddr_o,
  output logic           ack_o,
  output logic           cp_o,
  output logic           sof_o,
  output logic           ovf_o
);

  localparam logic [AddrW-1:0] RStart = AddrW'(NFft - CpLen);
  localparam logic [AddrW-1:0] RLast  = AddrW'(NFft - 1);

  logic [1:0]       full_q, full_d, full_set, full_clr;
  rd_state_e        state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [AddrW-1:0] rcnt_q, rcnt_d;
  logic             ack_q, cp_q, sof_q;
  logic             in_cp;

  cp_wr_ctrl #(
    .NFft  (NFft),
    .AddrW (AddrW)
  ) u_wr_ctrl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .ack_i   (ack_i),
    .full_i  (full_q),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .waddr_o (waddr_o),
    .set_o   (full_set),
    .ovf_o   (ovf_o)
  );

  assign re_o    = (state_q != StIdle) & rdy_i;
  assign raddr_o = {rbank_q, rcnt_q};
  assign in_cp   = (state_q == StCp);

  always_comb begin
    state_d  = state_q;
    rbank_d  = rbank_q;
    rcnt_d   = rcnt_q;
    full_clr = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (full_q[rbank_q]) begin
          state_d = StCp;
          rcnt_d  = RStart;
        end
      end
      StCp: begin
        if (re_o) begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == RLast) begin
            state_d = StBody;
          end
        end
      end
      StBody: begin
        if (re_o) begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == RLast) begin
            full_clr[rbank_q] = 1'b1;
            rbank_d           = ~rbank_q;
            // Chain straight into the next prefix when the other bank is ready.
            if (full_q[~rbank_q]) begin
              state_d = StCp;
              rcnt_d  = RStart;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Set and clear always target different banks, so both can apply in one cycle.
    full_d = (full_q | full_set) & ~full_clr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rbank_q <= 1'b0;
      rcnt_q  <= '0;
      full_q  <= 2'b00;
      ack_q   <= 1'b0;
      cp_q    <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rbank_q <= rbank_d;
      rcnt_q  <= rcnt_d;
      full_q  <= full_d;
      ack_q   <= re_o;
      cp_q    <= re_o & in_cp;
      sof_q   <= re_o & in_cp & (rcnt_q == RStart);
    end
  end

  assign ack_o = ack_q;
  assign cp_o  = cp_q;
  assign sof_o = sof_q;

endmodule

// File: tb/tb_cp_insert_sched.sv
// Directed bench for cp_insert_sched: writer vector table plus multi-cycle framing sequences.
module tb_cp_insert_sched;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       ack_i = 1'b0;
  logic       rdy_i = 1'b0;
  logic       stb_o, we_o, re_o, ack_o, cp_o, sof_o, ovf_o;
  logic [6:0] waddr_o, raddr_o;

  cp_insert_sched dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .ack_i   (ack_i),
    .stb_o   (stb_o),
    .rdy_i   (rdy_i),
    .we_o    (we_o),
    .waddr_o (waddr_o),
    .re_o    (re_o),
    .raddr_o (raddr_o),
    .ack_o   (ack_o),
    .cp_o    (cp_o),
    .sof_o   (sof_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [6:0] q_raddr[$];
  int         q_re_cyc[$];
  int         q_ack_cyc[$];
  logic [1:0] q_ack_fl[$];
  logic [6:0] q_waddr[$];
  int         we_cnt;
  int         last_we_cyc;
  int         first_stb_low;

  typedef struct {
    logic       rst;
    logic       ack;
    logic       rdy;
    logic       e_stb;
    logic       e_we;
    logic       e_re;
    logic       e_ack;
    logic [6:0] e_waddr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    q_raddr.delete();
    q_re_cyc.delete();
    q_ack_cyc.delete();
    q_ack_fl.delete();
    q_waddr.delete();
    we_cnt        = 0;
    last_we_cyc   = -1;
    first_stb_low = -1;
  endtask

  // Sample this cycle's outputs mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (re_o) begin
      q_raddr.push_back(raddr_o);
      q_re_cyc.push_back(cyc);
    end
    if (ack_o) begin
      q_ack_cyc.push_back(cyc);
      q_ack_fl.push_back({cp_o, sof_o});
    end
    if (we_o) begin
      q_waddr.push_back(waddr_o);
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (!stb_o && first_stb_low < 0) first_stb_low = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic rdy);
    rst_i = 1'b1;
    ack_i = 1'b0;
    rdy_i = rdy;
    tick();
    rst_i = 1'b0;
    clear_mon();
    cyc = 0;
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      ack_i = 1'b1;
      tick();
    end
    ack_i = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [6:0] exp_raddr(input int bank, input int k);
    int a;
    a = (k < 16) ? (48 + k) : (k - 16);
    return 7'(bank * 64 + a);
  endfunction

  function automatic int max_ack_gap();
    int m = 0;
    for (int i = 1; i < q_ack_cyc.size(); i++)
      if (q_ack_cyc[i] - q_ack_cyc[i-1] > m) m = q_ack_cyc[i] - q_ack_cyc[i-1];
    return m;
  endfunction

  function automatic int longest_ack_run();
    int best = 0;
    int run  = 0;
    for (int i = 0; i < q_ack_cyc.size(); i++) begin
      run = (i > 0 && q_ack_cyc[i] == q_ack_cyc[i-1] + 1) ? run + 1 : 1;
      if (run > best) best = run;
    end
    return best;
  endfunction

  task automatic check_symbol(input string tag, input int base, input int bank);
    logic [6:0] a;
    logic [1:0] f;
    for (int k = 0; k < 80; k++) begin
      a = (base + k < q_raddr.size()) ? q_raddr[base + k] : 7'h7f;
      check($sformatf("%s_raddr%0d", tag, k), 32'(a), 32'(exp_raddr(bank, k)));
      f = (base + k < q_ack_fl.size()) ? q_ack_fl[base + k] : 2'b11;
      check($sformatf("%s_cpsof%0d", tag, k), 32'(f), {30'd0, (k < 16), (k == 0)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_mon();
    // Writer-side vectors: {rst, ack, rdy, stb, we, re, ack_o, waddr}.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd2};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd2};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd3};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd4};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0};

    do_reset(1'b0);
    check("rst_stb", 32'(stb_o), 1);
    check("rst_ovf", 32'(ovf_o), 0);
    check("rst_ack", 32'(ack_o), 0);
    check("rst_full", 32'(dut.full_q), 0);
    for (int i = 0; i < 8; i++) begin
      rst_i = vecs[i].rst;
      ack_i = vecs[i].ack;
      rdy_i = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_stb", i), 32'(stb_o), 32'(vecs[i].e_stb));
      check($sformatf("vec%0d_we", i), 32'(we_o), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_re", i), 32'(re_o), 32'(vecs[i].e_re));
      check($sformatf("vec%0d_ack", i), 32'(ack_o), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d_waddr", i), 32'(waddr_o), 32'(vecs[i].e_waddr));
      tick();
    end

    // Single symbol: 64 writes then 80 prefix+body reads.
    do_reset(1'b1);
    write_n(64);
    idle_n(100);
    check("t1_last_we", last_we_cyc, 63);
    check("t1_re_cnt", q_raddr.size(), 80);
    check("t1_ack_cnt", q_ack_cyc.size(), 80);
    check("t1_first_re", (q_re_cyc.size() > 0) ? q_re_cyc[0] : -1, 65);
    check("t1_first_ack_lat", (q_ack_cyc.size() > 0) ? q_ack_cyc[0] - last_we_cyc : -1, 3);
    check_symbol("t1", 0, 0);

    // Upstream writes whenever ready: gapless two-symbol output, no overflow.
    do_reset(1'b1);
    for (int i = 0; i < 200; i++) begin
      ack_i = stb_o;
      tick();
    end
    ack_i = 1'b0;
    idle_n(150);
    check("t2_stb_drop", first_stb_low, 128);
    check("t2_we_cnt", we_cnt, 183);
    check("t2_ack_cnt", q_ack_cyc.size(), 160);
    check("t2_run", longest_ack_run(), 160);
    check("t2_ovf", 32'(ovf_o), 0);

    // Bank 1 completes on the same cycle bank 0 is released.
    do_reset(1'b1);
    write_n(64);
    idle_n(17);
    write_n(64);
    check("t6_cyc", cyc, 145);
    check("t6_full", 32'(dut.full_q), 32'(2'b10));
    check("t6_stb", 32'(stb_o), 1);
    idle_n(100);
    check("t6_re_cnt", q_raddr.size(), 160);
    check("t6_sym2_re", (q_re_cyc.size() > 80) ? q_re_cyc[80] : -1, 146);
    check("t6_sym2_addr", (q_raddr.size() > 80) ? 32'(q_raddr[80]) : 32'hffff, 32'h70);
    check("t6_full_end", 32'(dut.full_q), 0);

    // Downstream stall of 5 cycles mid-body.
    do_reset(1'b1);
    write_n(64);
    for (int i = 0; i < 200 && q_raddr.size() < 40; i++) tick();
    rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t3_hold_addr%0d", i), 32'(raddr_o), 24);
      check($sformatf("t3_hold_re%0d", i), 32'(re_o), 0);
      tick();
    end
    rdy_i = 1'b1;
    idle_n(100);
    check("t3_ack_cnt", q_ack_cyc.size(), 80);
    check("t3_gap", max_ack_gap(), 6);
    check_symbol("t3", 0, 0);

    // Overflow: both banks full, upstream keeps offering samples.
    do_reset(1'b0);
    write_n(128);
    check("t4_we_cnt", we_cnt, 128);
    check("t4_stb", 32'(stb_o), 0);
    check("t4_ovf_pre", 32'(ovf_o), 0);
    for (int i = 0; i < 10; i++) begin
      ack_i = 1'b1;
      #1;
      check($sformatf("t4_we%0d", i), 32'(we_o), 0);
      tick();
      check($sformatf("t4_ovf%0d", i), 32'(ovf_o), 1);
    end
    ack_i = 1'b0;
    rdy_i = 1'b1;
    idle_n(200);
    check("t4_ovf_sticky", 32'(ovf_o), 1);
    check("t4_drained", 32'(stb_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t4_ovf_rst", 32'(ovf_o), 0);

    // Reset during the prefix discards everything.
    do_reset(1'b1);
    write_n(64);
    for (int i = 0; i < 200 && q_raddr.size() < 5; i++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t5_ack", 32'(ack_o), 0);
    check("t5_cp", 32'(cp_o), 0);
    check("t5_stb", 32'(stb_o), 1);
    check("t5_re", 32'(re_o), 0);
    check("t5_full", 32'(dut.full_q), 0);
    clear_mon();
    write_n(64);
    for (int i = 0; i < 64; i++)
      check($sformatf("t5_waddr%0d", i), (i < q_waddr.size()) ? 32'(q_waddr[i]) : 32'hffff, i);
    idle_n(100);
    check("t5_ack_cnt", q_ack_cyc.size(), 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp_insert_sched.md
# cp_insert_sched

Controller that sequences cyclic-prefix insertion for the OFDM transmit path. Frequency-domain/IFFT samples arrive one per strobe and are written into a two-bank ping-pong sample RAM. Each full bank is replayed downstream as CP_LEN prefix samples, taken from the tail of the symbol, followed by the complete N_FFT-sample symbol. The block owns only the addressing, bank ownership, handshakes and framing flags. The sample RAM and the real/imag data path are external.

## Interface
- N_FFT, 64, samples per OFDM symbol (power of two)
- CP_LEN, 16, prefix length, 1..N_FFT-1
- ADDR_W, 6, log2(N_FFT)
- CLK_I  in  1  single clock, all logic on rising edge
- RST_I  in  1  reset; synchronous and active-high
- ACK_I  in  1  upstream sample valid, one sample per cycle when high
- STB_O  out  1  write-side ready: high when the current write bank is not full
- RDY_I  in  1  downstream ready; gates issue of the next read
- WE_O  out  1  RAM write enable = ACK_I & STB_O (combinational)
- WADDR_O  out  ADDR_W+1  {write bank, write count}
- RE_O  out  1  RAM read enable
- RADDR_O  out  ADDR_W+1  {read bank, read index}
- ACK_O  out  1  output sample valid, aligned with RAM data (RAM read latency 1)
- CP_O  out  1  high with ACK_O while the sample belongs to the prefix
- SOF_O  out  1  one-cycle pulse with the first ACK_O of each symbol
- OVF_O  out  1  sticky: ACK_I seen while STB_O low

## Operation
- State: wbank, wcnt, full[1:0], rbank, rcnt, read FSM {IDLE, CP, BODY}.
- Writer:
  - On WE_O, wcnt increments.
  - On the write with wcnt = N_FFT-1: set full[wbank], toggle wbank, wcnt wraps to 0.
  - STB_O = !full[wbank].
  - ACK_I while STB_O is low: the sample is dropped and OVF_O is set.
- Reader FSM:
  - IDLE: if full[rbank], go to CP with rcnt = N_FFT-CP_LEN.
  - CP: each issued read increments rcnt. After the read at rcnt = N_FFT-1, go to BODY with rcnt = 0.
  - BODY: each issued read increments rcnt. After the read at rcnt = N_FFT-1: clear full[rbank] and toggle rbank. If the other bank is already full, go directly to CP (gapless output); otherwise go to IDLE.
  - A read is issued when RE_O = (state≠IDLE) & RDY_I. RADDR_O = {rbank, rcnt}.
  - RDY_I low: rcnt and state hold and no read is issued.
- Output stage, registered from the read issue:
  - ACK_O <= RE_O.
  - CP_O <= RE_O & (state==CP).
  - SOF_O <= RE_O & (state==CP) & (rcnt==N_FFT-CP_LEN).
- Simultaneous events:
  - Writer set and reader clear in the same cycle always hit different banks, so both take effect.
  - The writer cannot touch a full bank.
- Arithmetic: all counters are ADDR_W bits and wrap modulo N_FFT. There is no saturation.

## Timing
- Reset values:
  - STB_O = 1.
  - All other outputs = 0.
  - wbank = rbank = 0, full = 00, state IDLE, OVF_O cleared.
- Reset mid-operation: any in-flight symbol and all buffered data are discarded. Outputs reach reset values at the first edge with RST_I high.
- Latency, with the last write of a bank in cycle t:
  - full is visible in t+1.
  - First RE_O in t+2.
  - First ACK_O/SOF_O in t+3.
- Each symbol produces N_FFT+CP_LEN ACK_O pulses: 80 by default.
- Sustained input is limited to N_FFT per N_FFT+CP_LEN cycles. STB_O enforces this limit.
- RDY_I is sampled per cycle. Downstream must absorb the one sample already in flight after it drops RDY_I.

## Structure
- Shared package cp_pkg:
  - N_FFT, CP_LEN, ADDR_W defaults.
  - Read-FSM state encoding (IDLE/CP/BODY).
  - This package is reused by the CP-delete side.
- Natural sub-module: cp_wr_ctrl, containing wbank, wcnt, the full-flag set path, STB_O/WE_O and OVF_O. The reader FSM and the full-flag clear path stay in the top level.

## Test plan
- Reset, then 64 back-to-back ACK_I with RDY_I=1:
  - RADDR_O walks {0,48..63} then {0,0..63}.
  - 80 ACK_O pulses, with the first one 3 cycles after the last write.
  - CP_O high for the first 16 pulses; SOF_O on the first pulse only.
- Continuous ACK_I for 200 cycles:
  - STB_O drops once both banks are full.
  - Output is gapless across the bank switch (160 consecutive ACK_O over two symbols).
  - No OVF_O.
- RDY_I low for 5 cycles mid-BODY:
  - RADDR_O holds.
  - ACK_O gap of exactly 5 cycles.
  - The sample sequence stays contiguous, with none lost or repeated.
- ACK_I held high while STB_O=0:
  - WE_O stays 0 and OVF_O rises and stays high.
  - OVF_O is cleared only by RST_I.
- RST_I asserted during the CP phase:
  - Next cycle: ACK_O=0, STB_O=1, full=00.
  - The next 64 writes land at bank 0, address 0 onward.
- Write completion and read release in the same cycle: bank 1 becomes full while bank 0 is freed, and both flags update correctly.
